// File: rtl/md_ctrl.sv
// md_ctrl: EX-stage multiply/divide sequencer.
// Runs one MULT/MULTU/DIV/DIVU at a time and holds the stall request until the
// HI/LO values are ready. Multiplies go through a MUL_LAT-deep product pipe.
// Divides use a 32-step radix-2 restoring divider on operand magnitudes,
// followed by a sign fix-up.
// Optional feature macro: MD_DIVZERO_FAST_EN. When it is defined, a zero
// divisor finishes after one step instead of 32. The result is identical.
module md_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        ex_go,
  input  logic        annul,
  output logic        stallreq,
  output logic        res_valid,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [5:0] MulLast = 6'(MUL_LAT - 1);
  localparam logic [5:0] DivLast = 6'd31;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic        sign1_q;
  logic        sign2_q;
  logic [31:0] opA_q;
  logic [31:0] opB_q;
  logic [31:0] divDvd_q;
  logic [31:0] divRem_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        resValid_q;

  // Operand magnitudes, captured at the accept edge.
  logic [31:0] mag1;
  logic [31:0] mag2;
  assign mag1 = (op[0] && src1[31]) ? (32'd0 - src1) : src1;
  assign mag2 = (op[0] && src2[31]) ? (32'd0 - src2) : src2;

  // Product of the latched magnitudes. The sign is applied before the pipe.
  logic [63:0] prodMag;
  logic [63:0] prodNow;
  logic [63:0] prodOut;
  assign prodMag = {32'd0, opA_q} * {32'd0, opB_q};
  assign prodNow = (sign1_q ^ sign2_q) ? (64'd0 - prodMag) : prodMag;

  generate
    if (MUL_LAT > 1) begin : gPipe
      logic [63:0] prodPipe_q [MUL_LAT-1];

      // Product pipe: stage i holds the product after edge E(i+1).
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < MUL_LAT - 1; i++) prodPipe_q[i] <= '0;
        end else begin
          prodPipe_q[0] <= prodNow;
          for (int i = 1; i < MUL_LAT - 1; i++) prodPipe_q[i] <= prodPipe_q[i-1];
        end
      end

      assign prodOut = prodPipe_q[MUL_LAT-2];
    end else begin : gNoPipe
      assign prodOut = prodNow;
    end
  endgenerate

  // One restoring-divide step. The remainder stays below the divisor, so it
  // fits in 32 bits. Only the shifted value needs the 33rd bit for the compare.
  // The low 32 bits of the difference are exact, even when computed mod 2^32.
  logic [32:0] remShift;
  logic        divGe;
  logic [31:0] remDiff;
  logic [31:0] remNext;
  logic [31:0] quoNext;
  logic [31:0] quoFix;
  logic [31:0] remFix;
  assign remShift = {divRem_q, divDvd_q[31]};
  assign divGe    = (remShift >= {1'b0, opB_q});
  assign remDiff  = remShift[31:0] - opB_q;
  assign remNext  = divGe ? remDiff : remShift[31:0];
  assign quoNext  = {divDvd_q[30:0], divGe};
  assign quoFix   = (sign1_q ^ sign2_q) ? (32'd0 - quoNext) : quoNext;
  assign remFix   = sign1_q ? (32'd0 - remNext) : remNext;

  // Sequencer FSM. It also holds the operand, divider and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      opA_q      <= '0;
      opB_q      <= '0;
      divDvd_q   <= '0;
      divRem_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      resValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_valid && !annul) begin
            state_q  <= op[1] ? DIV : MUL;
            sign1_q  <= src1[31] & op[0];
            sign2_q  <= src2[31] & op[0];
            opA_q    <= mag1;
            opB_q    <= mag2;
            divDvd_q <= mag1;
            divRem_q <= '0;
            cnt_q    <= '0;
          end
        end
        MUL: begin
          if (annul) begin
            state_q    <= IDLE;
            resValid_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == MulLast) begin
              state_q    <= DONE;
              hi_q       <= prodOut[63:32];
              lo_q       <= prodOut[31:0];
              resValid_q <= 1'b1;
            end
          end
        end
        DIV: begin
          if (annul) begin
            state_q    <= IDLE;
            resValid_q <= 1'b0;
          end else begin
            cnt_q    <= cnt_q + 6'd1;
            divRem_q <= remNext;
            divDvd_q <= quoNext;
`ifdef MD_DIVZERO_FAST_EN
            if (opB_q == 32'd0) begin
              state_q    <= DONE;
              lo_q       <= (sign1_q ^ sign2_q) ? 32'd1 : 32'hFFFF_FFFF;
              hi_q       <= sign1_q ? (32'd0 - opA_q) : opA_q;
              resValid_q <= 1'b1;
            end else
`endif
            if (cnt_q == DivLast) begin
              state_q    <= DONE;
              lo_q       <= quoFix;
              hi_q       <= remFix;
              resValid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (annul || ex_go) begin
            state_q    <= IDLE;
            resValid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          resValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign stallreq  = resetn & op_valid & (state_q != DONE) & ~annul;
  assign res_valid = resValid_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed testbench for md_ctrl with the default MUL_LAT=2.
// Expected HI/LO values and latencies are worked out by hand.
module tb_md_ctrl;

  logic        clk;
  logic        resetn;
  logic        op_valid;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        ex_go;
  logic        annul;
  logic        stallreq;
  logic        res_valid;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int compared;
  int mismatched;

  localparam int MulLat = 2;
  localparam int DivLat = 32;
`ifdef MD_DIVZERO_FAST_EN
  localparam int DivZeroLat = 1;
`else
  localparam int DivZeroLat = 32;
`endif

  md_ctrl #(.MUL_LAT(MulLat)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .op_valid  (op_valid),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .ex_go     (ex_go),
    .annul     (annul),
    .stallreq  (stallreq),
    .res_valid (res_valid),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value with its expected value and logs mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one op from IDLE and waits for the result with a bounded cycle count.
  // It checks the latency, the number of stall cycles and the HI/LO values.
  // The task starts and ends 1 ns after a rising edge.
  task automatic applyStimulus(input string tag, input logic [1:0] opIn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expHi, input logic [31:0] expLo,
                               input int expLat, input bit holdDone);
    int lat;
    int stallCnt;
    op_valid = 1'b1;
    op       = opIn;
    src1     = a;
    src2     = b;
    #1;
    checkOutput({tag, " stall@E0"}, 64'(stallreq), 64'd1);
    @(posedge clk); #1;
    lat      = 0;
    stallCnt = 0;
    while (!res_valid && lat < 40) begin
      if (stallreq) stallCnt++;
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, " stallcycles"}, 64'(stallCnt), 64'(expLat));
    checkOutput({tag, " hi"}, 64'(hi_o), 64'(expHi));
    checkOutput({tag, " lo"}, 64'(lo_o), 64'(expLo));
    checkOutput({tag, " stall@DONE"}, 64'(stallreq), 64'd0);
    if (!holdDone) begin
      op_valid = 1'b0;
      ex_go    = 1'b1;
      @(posedge clk); #1;
      ex_go = 1'b0;
      checkOutput({tag, " release"}, 64'(res_valid), 64'd0);
    end
  endtask

  // Directed sequence: reset, mul/div vectors, annul, DONE hold, mid-op reset.
  initial begin
    compared   = 0;
    mismatched = 0;
    resetn     = 1'b0;
    op_valid   = 1'b0;
    op         = 2'b00;
    src1       = '0;
    src2       = '0;
    ex_go      = 1'b0;
    annul      = 1'b0;
    #12;
    checkOutput("reset res_valid", 64'(res_valid), 64'd0);
    checkOutput("reset hi", 64'(hi_o), 64'd0);
    checkOutput("reset lo", 64'(lo_o), 64'd0);
    checkOutput("reset stall", 64'(stallreq), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    applyStimulus("multu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'hFFFF_FFFE, 32'h0000_0001, MulLat, 1'b0);
    applyStimulus("mult -3x5", 2'b01, 32'hFFFF_FFFD, 32'd5,
                  32'hFFFF_FFFF, 32'hFFFF_FFF1, MulLat, 1'b0);
    applyStimulus("div -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2,
                  32'hFFFF_FFFF, 32'hFFFF_FFFD, DivLat, 1'b0);
    applyStimulus("div min/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
                  32'h0000_0000, 32'h8000_0000, DivLat, 1'b0);
    applyStimulus("divu max/16", 2'b10, 32'hFFFF_FFFF, 32'd16,
                  32'h0000_000F, 32'h0FFF_FFFF, DivLat, 1'b0);
    applyStimulus("div -5/0", 2'b11, 32'hFFFF_FFFB, 32'd0,
                  32'hFFFF_FFFB, 32'h0000_0001, DivZeroLat, 1'b0);
    applyStimulus("divu 100/0", 2'b10, 32'd100, 32'd0,
                  32'h0000_0064, 32'hFFFF_FFFF, DivZeroLat, 1'b0);

    // Annul during divide step 10. The outputs keep the divu 100/0 result.
    op_valid = 1'b1;
    op       = 2'b10;
    src1     = 32'd1000;
    src2     = 32'd7;
    @(posedge clk); #1;
    repeat (9) begin
      @(posedge clk); #1;
    end
    annul = 1'b1;
    #1;
    checkOutput("annul stall", 64'(stallreq), 64'd0);
    @(posedge clk); #1;
    annul    = 1'b0;
    op_valid = 1'b0;
    checkOutput("annul res_valid", 64'(res_valid), 64'd0);
    checkOutput("annul hi held", 64'(hi_o), 64'h0000_0064);
    checkOutput("annul lo held", 64'(lo_o), 64'hFFFF_FFFF);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("annul idle res_valid", 64'(res_valid), 64'd0);
    end

    // Divide after annul must restart from IDLE. Then hold DONE with op_valid high.
    applyStimulus("divu 9/3", 2'b10, 32'd9, 32'd3, 32'd0, 32'd3, DivLat, 1'b1);
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("hold res_valid", 64'(res_valid), 64'd1);
      checkOutput("hold stall", 64'(stallreq), 64'd0);
      checkOutput("hold hi", 64'(hi_o), 64'd0);
      checkOutput("hold lo", 64'(lo_o), 64'd3);
    end
    op_valid = 1'b0;
    ex_go    = 1'b1;
    @(posedge clk); #1;
    ex_go = 1'b0;
    checkOutput("hold release", 64'(res_valid), 64'd0);

    // Asynchronous reset in the middle of a divide clears the outputs at once.
    op_valid = 1'b1;
    op       = 2'b11;
    src1     = 32'd1000;
    src2     = 32'd7;
    @(posedge clk); #1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("midreset hi", 64'(hi_o), 64'd0);
    checkOutput("midreset lo", 64'(lo_o), 64'd0);
    checkOutput("midreset res_valid", 64'(res_valid), 64'd0);
    checkOutput("midreset stall", 64'(stallreq), 64'd0);
    op_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    applyStimulus("post-reset mult", 2'b01, 32'hFFFF_FFFD, 32'd5,
                  32'hFFFF_FFFF, 32'hFFFF_FFF1, MulLat, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
